// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and helpers for the MEM-stage access unit.
//   - funct3 access-size encodings (B/H/W/D and unsigned variants)
//   - FSM state encodings for mem_access_unit
//   - helpers for alignment checking and size masks/strobes
package mem_pkg;

    localparam int unsigned RV_XLEN = 64;

    // funct3 load/store size encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Misaligned for the access size, or an encoding that has no access size (111).
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] off);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = off[0];
            F3_W, F3_WU: bad = |off[1:0];
            F3_D:        bad = |off;
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Data mask for an access size, right-justified.
    function automatic logic [RV_XLEN-1:0] size_mask(input logic [1:0] sz);
        logic [RV_XLEN-1:0] m;
        m = '0;
        case (sz)
            2'b00:   m = 64'h0000_0000_0000_00FF;
            2'b01:   m = 64'h0000_0000_0000_FFFF;
            2'b10:   m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    // Byte strobes for an access size, before the lane shift.
    function automatic logic [7:0] size_strb(input logic [1:0] sz);
        logic [7:0] s;
        s = '0;
        case (sz)
            2'b00:   s = 8'h01;
            2'b01:   s = 8'h03;
            2'b10:   s = 8'h0F;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// load_formatter: combinational load-data formatter.
// Selects the addressed byte lane from a doubleword and sign- or zero-extends it.
// Ports:
//   rdata     in  64  raw doubleword read data
//   addr_lo   in  3   byte offset within the doubleword
//   funct3    in  3   access size and signedness
//   read_data out 64  extended load result
module load_formatter
    import mem_pkg::*;
(
    input  logic [RV_XLEN-1:0] rdata,
    input  logic [2:0]         addr_lo,
    input  logic [2:0]         funct3,
    output logic [RV_XLEN-1:0] read_data
);

    logic [RV_XLEN-1:0] shifted;

    // Move the addressed byte to bit 0 so every size extends from the low end.
    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        read_data = '0;
        case (funct3)
            F3_B:    read_data = {{56{shifted[7]}}, shifted[7:0]};
            F3_H:    read_data = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    read_data = {{32{shifted[31]}}, shifted[31:0]};
            F3_BU:   read_data = {56'd0, shifted[7:0]};
            F3_HU:   read_data = {48'd0, shifted[15:0]};
            F3_WU:   read_data = {32'd0, shifted[31:0]};
            default: read_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage controller for the 5-stage RV64I pipeline.
// Runs loads/stores against a req/ready data memory, aligns store data and strobes,
// formats load data, passes control/result fields through to MEM/WB and stalls the
// upstream stages while an access is outstanding.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   MemRead, MemWrite, funct3         access request from EX/MEM
//   ALU_result, WriteData             address / result and store data
//   RegWrite_in, MemtoReg_in, rd_in   control passed to MEM/WB
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_wstrb              memory request side
//   mem_ready, mem_rdata              memory response side
//   RegWrite, MemtoReg, ReadData,
//   ALU_result_out, rd                to MEM/WB
//   stall, misalign, mem_timeout      pipeline control / status pulses
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] ALU_result,
    input  logic [XLEN-1:0] WriteData,
    input  logic            RegWrite_in,
    input  logic            MemtoReg_in,
    input  logic [4:0]      rd_in,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wstrb,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            RegWrite,
    output logic            MemtoReg,
    output logic [XLEN-1:0] ReadData,
    output logic [XLEN-1:0] ALU_result_out,
    output logic [4:0]      rd,
    output logic            stall,
    output logic            misalign,
    output logic            mem_timeout
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]      state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rbuf_q, rbuf_d;
    logic            to_q, to_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [7:0]      wstrb_q, wstrb_d;

    logic            memop;
    logic            bad_align;
    logic            is_store;
    logic [2:0]      offset;
    logic [XLEN-1:0] wdata_lane;
    logic [7:0]      wstrb_lane;
    logic [XLEN-1:0] fmt_data;

    assign memop     = MemRead | MemWrite;
    assign offset    = ALU_result[2:0];
    assign bad_align = is_misaligned(funct3, offset);
    // A load wins when both request bits are set.
    assign is_store  = MemWrite & ~MemRead;

    assign wdata_lane = (WriteData & size_mask(funct3[1:0])) << {offset, 3'b000};
    assign wstrb_lane = size_strb(funct3[1:0]) << offset;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rbuf_d  = rbuf_q;
        to_d    = 1'b0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            ST_IDLE: begin
                if (memop && !bad_align) begin
                    state_d = ST_ACCESS;
                    cnt_d   = '0;
                    we_d    = is_store;
                    addr_d  = {ALU_result[XLEN-1:3], 3'b000};
                    wdata_d = wdata_lane;
                    wstrb_d = wstrb_lane;
                end
            end
            ST_ACCESS: begin
                if (mem_ready) begin
                    rbuf_d  = mem_rdata;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else if (cnt_q == TO_LAST) begin
                    // Abort: hand an all-zero result to DONE and flag it there.
                    rbuf_d  = '0;
                    cnt_d   = '0;
                    to_d    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rbuf_q  <= '0;
            to_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rbuf_q  <= rbuf_d;
            to_q    <= to_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    load_formatter u_load_formatter (
        .rdata     (rbuf_q),
        .addr_lo   (offset),
        .funct3    (funct3),
        .read_data (fmt_data)
    );

    // Request outputs decode from registered state, so reset drops them at once.
    assign mem_req   = (state_q == ST_ACCESS);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;

    assign stall       = ((state_q == ST_IDLE) && memop && !bad_align) || (state_q == ST_ACCESS);
    assign misalign    = (state_q == ST_IDLE) && memop && bad_align;
    // to_q is only ever set on the ACCESS->DONE edge, so it is high exactly in DONE.
    assign mem_timeout = to_q;

    assign ReadData       = (state_q == ST_DONE) ? fmt_data : '0;
    assign RegWrite       = RegWrite_in & ~misalign & ~((state_q == ST_DONE) & to_q);
    assign MemtoReg       = MemtoReg_in;
    assign ALU_result_out = ALU_result;
    assign rd             = rd_in;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
// Expected DONE-cycle results are queued when an access is launched and popped
// when the unit drops stall; a small responder answers mem_req after N waits.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [63:0] ALU_result, WriteData;
    logic        RegWrite_in, MemtoReg_in;
    logic [4:0]  rd_in;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic        RegWrite, MemtoReg;
    logic [63:0] ReadData, ALU_result_out;
    logic [4:0]  rd;
    logic        stall, misalign, mem_timeout;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [63:0] rdata;
        logic        regwr;
        logic [31:0] stalls;
        logic        to;
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } exp_t;

    exp_t exp_q[$];

    mem_access_unit #(
        .XLEN    (64),
        .TIMEOUT (4),
        .TO_W    (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .funct3         (funct3),
        .ALU_result     (ALU_result),
        .WriteData      (WriteData),
        .RegWrite_in    (RegWrite_in),
        .MemtoReg_in    (MemtoReg_in),
        .rd_in          (rd_in),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .RegWrite       (RegWrite),
        .MemtoReg       (MemtoReg),
        .ReadData       (ReadData),
        .ALU_result_out (ALU_result_out),
        .rd             (rd),
        .stall          (stall),
        .misalign       (misalign),
        .mem_timeout    (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic drive_idle(input logic [63:0] alu, input logic [4:0] r);
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        funct3      = 3'b000;
        ALU_result  = alu;
        WriteData   = 64'd0;
        RegWrite_in = 1'b1;
        MemtoReg_in = 1'b0;
        rd_in       = r;
    endtask

    // Called just after a posedge; returns just after a posedge with the unit idle.
    task automatic run_op(input string tag, input logic rd_en, input logic wr_en,
                          input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wd, input logic [63:0] resp,
                          input int waits, input logic never, input logic rw_in,
                          input exp_t e_in);
        int   acc;
        int   sc;
        logic done;
        exp_t e;
        exp_q.push_back(e_in);
        MemRead     = rd_en;
        MemWrite    = wr_en;
        funct3      = f3;
        ALU_result  = addr;
        WriteData   = wd;
        RegWrite_in = rw_in;
        MemtoReg_in = rd_en;
        rd_in       = 5'd10;
        acc  = 0;
        sc   = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (mem_req) begin
                acc++;
                if (acc == 1) begin
                    chk({tag, ".mem_addr"}, mem_addr, e_in.addr);
                    chk({tag, ".mem_we"}, 64'(mem_we), 64'(e_in.we));
                    if (wr_en && !rd_en) begin
                        chk({tag, ".mem_wdata"}, mem_wdata, e_in.wdata);
                        chk({tag, ".mem_wstrb"}, 64'(mem_wstrb), 64'(e_in.wstrb));
                    end
                end
                mem_rdata = resp;
                mem_ready = !never && (acc > waits);
            end else begin
                mem_ready = 1'b0;
            end
            if (stall) begin
                sc++;
            end else begin
                done = 1'b1;
                e = exp_q.pop_front();
                chk({tag, ".ReadData"}, ReadData, e.rdata);
                chk({tag, ".RegWrite"}, 64'(RegWrite), 64'(e.regwr));
                chk({tag, ".stall_cycles"}, 64'(sc), 64'(e.stalls));
                chk({tag, ".mem_timeout"}, 64'(mem_timeout), 64'(e.to));
                chk({tag, ".req_done"}, 64'(mem_req), 64'd0);
            end
        end
        chk({tag, ".completed"}, 64'(done), 64'd1);
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        drive_idle(64'h1111, 5'd3);
        @(negedge clk);
        chk({tag, ".idle_stall"}, 64'(stall), 64'd0);
        chk({tag, ".idle_timeout"}, 64'(mem_timeout), 64'd0);
        chk({tag, ".idle_rdata"}, ReadData, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic mis_op(input string tag, input logic wr_en, input logic [2:0] f3,
                          input logic [63:0] addr);
        MemRead     = !wr_en;
        MemWrite    = wr_en;
        funct3      = f3;
        ALU_result  = addr;
        RegWrite_in = 1'b1;
        @(negedge clk);
        chk({tag, ".misalign"}, 64'(misalign), 64'd1);
        chk({tag, ".mem_req"}, 64'(mem_req), 64'd0);
        chk({tag, ".RegWrite"}, 64'(RegWrite), 64'd0);
        chk({tag, ".stall"}, 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        drive_idle(64'h1111, 5'd3);
        @(negedge clk);
        chk({tag, ".pulse_end"}, 64'(misalign), 64'd0);
        chk({tag, ".no_req"}, 64'(mem_req), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 64'd0;
        drive_idle(64'd0, 5'd0);
        #3;
        chk("rst.mem_req", 64'(mem_req), 64'd0);
        chk("rst.mem_we", 64'(mem_we), 64'd0);
        chk("rst.mem_addr", mem_addr, 64'd0);
        chk("rst.mem_wdata", mem_wdata, 64'd0);
        chk("rst.mem_wstrb", 64'(mem_wstrb), 64'd0);
        chk("rst.stall", 64'(stall), 64'd0);
        chk("rst.misalign", 64'(misalign), 64'd0);
        chk("rst.mem_timeout", 64'(mem_timeout), 64'd0);
        chk("rst.ReadData", ReadData, 64'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Non-memory op passes straight through
        drive_idle(64'h0000_0000_CAFE_0001, 5'd17);
        MemtoReg_in = 1'b1;
        @(negedge clk);
        chk("add.RegWrite", 64'(RegWrite), 64'd1);
        chk("add.MemtoReg", 64'(MemtoReg), 64'd1);
        chk("add.ALU_out", ALU_result_out, 64'h0000_0000_CAFE_0001);
        chk("add.rd", 64'(rd), 64'd17);
        chk("add.stall", 64'(stall), 64'd0);
        chk("add.ReadData", ReadData, 64'd0);
        @(posedge clk);
        #1;

        //      tag    rd    wr    f3      addr                   wdata                  resp                   w  nev  rw
        run_op("lb", 1'b1, 1'b0, 3'b000, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 1'b0, 1'b1,
               '{rdata: 64'hFFFF_FFFF_FFFF_FF80, regwr: 1'b1, stalls: 32'd2, to: 1'b0,
                 addr: 64'h1000, we: 1'b0, wdata: 64'd0, wstrb: 8'd0});
        run_op("lhu", 1'b1, 1'b0, 3'b101, 64'h2006, 64'd0, 64'hBEEF_0000_0000_0000, 3, 1'b0, 1'b1,
               '{rdata: 64'h0000_0000_0000_BEEF, regwr: 1'b1, stalls: 32'd5, to: 1'b0,
                 addr: 64'h2000, we: 1'b0, wdata: 64'd0, wstrb: 8'd0});
        run_op("sh", 1'b0, 1'b1, 3'b001, 64'h3002, 64'h1234, 64'd0, 0, 1'b0, 1'b0,
               '{rdata: 64'd0, regwr: 1'b0, stalls: 32'd2, to: 1'b0,
                 addr: 64'h3000, we: 1'b1, wdata: 64'h0000_0000_1234_0000, wstrb: 8'h0C});
        run_op("ld", 1'b1, 1'b0, 3'b011, 64'h5008, 64'd0, 64'h0123_4567_89AB_CDEF, 1, 1'b0, 1'b1,
               '{rdata: 64'h0123_4567_89AB_CDEF, regwr: 1'b1, stalls: 32'd3, to: 1'b0,
                 addr: 64'h5008, we: 1'b0, wdata: 64'd0, wstrb: 8'd0});
        run_op("lw", 1'b1, 1'b0, 3'b010, 64'h6004, 64'd0, 64'h8765_4321_0000_0000, 0, 1'b0, 1'b1,
               '{rdata: 64'hFFFF_FFFF_8765_4321, regwr: 1'b1, stalls: 32'd2, to: 1'b0,
                 addr: 64'h6000, we: 1'b0, wdata: 64'd0, wstrb: 8'd0});
        run_op("lwu", 1'b1, 1'b0, 3'b110, 64'h6004, 64'd0, 64'h8765_4321_0000_0000, 2, 1'b0, 1'b1,
               '{rdata: 64'h0000_0000_8765_4321, regwr: 1'b1, stalls: 32'd4, to: 1'b0,
                 addr: 64'h6000, we: 1'b0, wdata: 64'd0, wstrb: 8'd0});
        run_op("sb", 1'b0, 1'b1, 3'b000, 64'h7005, 64'hFFFF_FFFF_FFFF_FFAB, 64'd0, 0, 1'b0, 1'b0,
               '{rdata: 64'd0, regwr: 1'b0, stalls: 32'd2, to: 1'b0,
                 addr: 64'h7000, we: 1'b1, wdata: 64'h0000_AB00_0000_0000, wstrb: 8'h20});
        run_op("sd", 1'b0, 1'b1, 3'b011, 64'h8000, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 1, 1'b0, 1'b0,
               '{rdata: 64'd0, regwr: 1'b0, stalls: 32'd3, to: 1'b0,
                 addr: 64'h8000, we: 1'b1, wdata: 64'hDEAD_BEEF_CAFE_F00D, wstrb: 8'hFF});
        run_op("rdwr", 1'b1, 1'b1, 3'b100, 64'h9001, 64'h55, 64'h0000_0000_0000_C300, 0, 1'b0, 1'b1,
               '{rdata: 64'h0000_0000_0000_00C3, regwr: 1'b1, stalls: 32'd2, to: 1'b0,
                 addr: 64'h9000, we: 1'b0, wdata: 64'd0, wstrb: 8'd0});
        run_op("tmo", 1'b1, 1'b0, 3'b001, 64'hA000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, 1'b1,
               '{rdata: 64'd0, regwr: 1'b0, stalls: 32'd5, to: 1'b1,
                 addr: 64'hA000, we: 1'b0, wdata: 64'd0, wstrb: 8'd0});

        mis_op("mis_lw", 1'b0, 3'b010, 64'h4002);
        mis_op("mis_sd", 1'b1, 3'b011, 64'h4004);
        mis_op("mis_lh", 1'b0, 3'b001, 64'h4001);
        mis_op("bad_f3", 1'b0, 3'b111, 64'h4000);

        // Reset while an access is outstanding
        MemRead    = 1'b1;
        funct3     = 3'b011;
        ALU_result = 64'hB000;
        @(negedge clk);
        @(negedge clk);
        chk("rstacc.req_before", 64'(mem_req), 64'd1);
        #2;
        rst_n = 1'b0;
        drive_idle(64'h2222, 5'd7);
        #1;
        chk("rstacc.mem_req", 64'(mem_req), 64'd0);
        chk("rstacc.stall", 64'(stall), 64'd0);
        chk("rstacc.mem_addr", mem_addr, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstacc.add_stall", 64'(stall), 64'd0);
        chk("rstacc.add_RegWrite", 64'(RegWrite), 64'd1);
        chk("rstacc.add_ALU_out", ALU_result_out, 64'h2222);
        chk("rstacc.add_req", 64'(mem_req), 64'd0);
        @(posedge clk);
        #1;
        run_op("lb_again", 1'b1, 1'b0, 3'b000, 64'h1003, 64'd0, 64'h0000_0000_7F00_0000, 0, 1'b0,
               1'b1, '{rdata: 64'h0000_0000_0000_007F, regwr: 1'b1, stalls: 32'd2, to: 1'b0,
                       addr: 64'h1000, we: 1'b0, wdata: 64'd0, wstrb: 8'd0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage controller between the EX/MEM register and the MEM/WB register of the 5-stage RV64I pipeline.
- Runs loads and stores against a data memory that uses a req/ready handshake.
- Aligns store data and generates byte strobes.
- Aligns and sign- or zero-extends load data.
- Passes RegWrite, MemtoReg, ALU_result and rd through to MEM/WB.
- Stalls upstream stages while an access is outstanding.

Parameters:
- XLEN, 64, datapath width (fixed RV64; 64 only)
- TIMEOUT, 255, maximum cycles in ACCESS before the access is aborted
- TO_W, 8, width of the timeout counter

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- MemRead  in  1  load request from EX/MEM
- MemWrite  in  1  store request from EX/MEM
- funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- ALU_result  in  64  effective address, or ALU result for non-memory ops
- WriteData  in  64  rs2 store data (right-justified)
- RegWrite_in  in  1  from EX/MEM
- MemtoReg_in  in  1  from EX/MEM
- rd_in  in  5  from EX/MEM
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = store
- mem_addr  out  64  doubleword-aligned address (ALU_result & ~7)
- mem_wdata  out  64  store data shifted to byte lane
- mem_wstrb  out  8  byte enables
- mem_ready  in  1  memory accepted the request / read data valid
- mem_rdata  in  64  doubleword read data
- RegWrite  out  1  to MEM/WB
- MemtoReg  out  1  to MEM/WB
- ReadData  out  64  formatted load data to MEM/WB
- ALU_result_out  out  64  to MEM/WB
- rd  out  5  to MEM/WB
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- misalign  out  1  one-cycle pulse on a misaligned access
- mem_timeout  out  1  one-cycle pulse on an aborted access

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. All state updates on posedge clk.
- Reset values:
  - State IDLE.
  - Timeout counter 0.
  - Read buffer 0.
  - mem_req, mem_we, stall, misalign, mem_timeout all 0.
  - mem_addr, mem_wdata, mem_wstrb all 0.
  - Pass-through outputs follow their inputs combinationally and are not reset.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - With memop = MemRead|MemWrite = 0: pass through; stall=0; ReadData=0.
  - With memop and aligned: stall=1, next state ACCESS.
  - With memop and misaligned: misalign=1, RegWrite forced to 0, stall=0, no memory request, stay IDLE.
  - Misaligned means: H with addr[0]≠0; W with addr[1:0]≠0; D with addr[2:0]≠0.
- ACCESS:
  - Drive mem_req=1, mem_we=MemWrite, mem_addr, mem_wdata and mem_wstrb; all stable until mem_ready.
  - stall=1. The counter increments each cycle.
  - On mem_ready=1: capture mem_rdata into the read buffer, clear the counter, go to DONE.
  - When the counter reaches TIMEOUT with no mem_ready: pulse mem_timeout, clear the read buffer to 0, force RegWrite=0 during DONE, go to DONE.
  - mem_ready is sampled only in ACCESS; it is ignored in IDLE and DONE.
- DONE:
  - stall=0, mem_req=0.
  - ReadData = formatted read buffer; outputs valid for the whole cycle.
  - EX/MEM advances at the closing edge; next state IDLE.
- Latency: load or store with zero wait states gives stall for 2 cycles (IDLE, ACCESS) and results in DONE, the 3rd cycle. Each wait cycle adds 1 stall cycle. Non-memory ops add 0 cycles.
- Store lane shift: mem_wdata = WriteData << (8*addr[2:0]), masked to the access size.
- Store strobes: B gives 0x01<<off; H gives 0x03<<off; W gives 0x0F<<off; D gives 0xFF.
- Load format: byte-select by addr[2:0], then sign-extend (B/H/W) or zero-extend (BU/HU/WU) to 64 bits. D is passed unchanged.
- Invalid funct3 (111) with memop: treated as misaligned (pulse misalign, no access).
- MemRead and MemWrite both 1: the load takes precedence.
- Reset mid-ACCESS: mem_req drops immediately and asynchronously; the memory must tolerate an abandoned request.

Decomposition:
- Package mem_pkg: funct3 size encodings, FSM state enum, XLEN constant.
- Sub-module load_formatter (combinational): inputs rdata, addr[2:0], funct3; output extended ReadData.

Test Plan:
- Load LB, addr=0x1003, mem_rdata=0x0000_0000_8000_0000 ready after 0 waits → stall 2 cycles; ReadData=0xFFFF_FFFF_FFFF_FF80 in DONE.
- Load LHU at addr=0x2006, mem_rdata=0xBEEF_0000_0000_0000, 3 wait cycles → stall 5 cycles; ReadData=0x0000_0000_0000_BEEF.
- Store SH, addr=0x3002, WriteData=0x1234 → mem_wstrb=0x0C, mem_wdata=0x0000_0000_1234_0000, mem_we=1, mem_addr=0x3000.
- LW at addr=0x4002 → misalign pulse 1 cycle; mem_req stays 0; RegWrite=0; stall=0.
- Load with mem_ready never asserted, TIMEOUT=4 → mem_timeout pulse after 4 ACCESS cycles; ReadData=0; RegWrite=0; back to IDLE.
- Reset asserted in ACCESS → mem_req, stall and state cleared same cycle; the next ADD op passes through with zero stall.
